instruction_decode: RTL and testbench

Decode (ID) stage of the 20-bit pipelined processor, sitting directly upstream of the execute stage (ALU with 2-bit control and operand-equality flag).
- Decodes the fetched instruction and reads the 8×20-bit register file.
- Registers operands and control into the ID/EX pipeline register.
- Detects load-use hazards, stalling fetch and inserting a bubble.
- Accepts the writeback port, with write-to-read bypass.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/register_file.sv | 43 ++++
 rtl/instruction_decode.sv | 134 +++++++++++++
 tb/tb_instruction_decode.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the 20-bit pipelined processor: opcodes, ALU controls,
// instruction field positions and the canonical NOP encoding.
package proc_pkg;

    localparam int DATA_W = 20;
    localparam int REG_N  = 8;
    localparam int REG_AW = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_OR  = 4'h1,
        OP_AND = 4'h2,
        OP_NOT = 4'h3,
        OP_LW  = 4'h4,
        OP_SW  = 4'h5,
        OP_BEQ = 4'h6,
        OP_NOP = 4'hF
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 13;
    localparam int RS1_MSB = 12;
    localparam int RS1_LSB = 10;
    localparam int RS2_MSB = 9;
    localparam int RS2_LSB = 7;

    localparam logic [DATA_W-1:0] NOP_INSTR = 20'hF0000;

endpackage

// File: rtl/register_file.sv
// 8x20 register file: three combinational read ports with write-to-read bypass,
// one synchronous write port, R0 hardwired to zero.
module register_file #(
    parameter int DATA_W = 20,
    parameter int REG_N  = 8,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    input  logic [ADDR_W-1:0] i_raddr3,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic [DATA_W-1:0] o_rdata3
);

    logic [DATA_W-1:0] r_regs [REG_N];
    logic              w_wr_live;

    assign w_wr_live = i_we && (i_waddr != '0);

    // NOTE: the array is small enough to clear on reset; a large RAM would be left unreset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
        end else if (w_wr_live) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 :
                      (w_wr_live && i_raddr1 == i_waddr) ? i_wdata : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 :
                      (w_wr_live && i_raddr2 == i_waddr) ? i_wdata : r_regs[i_raddr2];
    assign o_rdata3 = (i_raddr3 == '0) ? '0 :
                      (w_wr_live && i_raddr3 == i_waddr) ? i_wdata : r_regs[i_raddr3];

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decodes the IF/ID instruction, reads operands, detects load-use
// hazards and loads the ID/EX pipeline register (bubble on hazard/flush).
module instruction_decode #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int REG_N  = proc_pkg::REG_N
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] if_instruction,
    input  logic              if_valid,
    input  logic              ex_flush,
    input  logic              wb_we,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_instruction,
    output logic [1:0]        ex_control,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_rfReadData2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [2:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch
);
    import proc_pkg::*;

    logic [3:0]        w_opcode;
    logic [2:0]        w_rd, w_rs1, w_rs2;
    logic [DATA_W-1:0] w_rdata1, w_rdata2, w_rdata3;
    logic              w_legal, w_uses_rs2, w_uses_rd;
    logic              w_reg_write, w_mem_read, w_mem_write, w_branch;
    logic [1:0]        w_control;
    logic              w_hazard, w_bubble;

    logic              r_ex_valid, r_ex_reg_write, r_ex_mem_read, r_ex_mem_write, r_ex_branch;
    logic [DATA_W-1:0] r_ex_instruction, r_ex_opA, r_ex_opB, r_ex_store;
    logic [1:0]        r_ex_control;
    logic [2:0]        r_ex_rd;

    assign w_opcode = if_instruction[OPC_MSB:OPC_LSB];
    assign w_rd     = if_instruction[RD_MSB:RD_LSB];
    assign w_rs1    = if_instruction[RS1_MSB:RS1_LSB];
    assign w_rs2    = if_instruction[RS2_MSB:RS2_LSB];

    register_file #(.DATA_W(DATA_W), .REG_N(REG_N), .ADDR_W(3)) u_rf (
        .clock    (clock),
        .reset    (reset),
        .i_we     (wb_we),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data),
        .i_raddr1 (w_rs1),
        .i_raddr2 (w_rs2),
        .i_raddr3 (w_rd),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .o_rdata3 (w_rdata3)
    );

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        w_legal     = 1'b1;
        w_control   = ALU_ADD;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_uses_rs2  = 1'b1;
        w_uses_rd   = 1'b0;
        case (w_opcode)
            OP_ADD: w_reg_write = 1'b1;
            OP_OR:  begin w_reg_write = 1'b1; w_control = ALU_OR;  end
            OP_AND: begin w_reg_write = 1'b1; w_control = ALU_AND; end
            OP_NOT: begin w_reg_write = 1'b1; w_control = ALU_NOT; w_uses_rs2 = 1'b0; end
            OP_LW:  begin w_reg_write = 1'b1; w_mem_read = 1'b1; end
            OP_SW:  begin w_mem_write = 1'b1; w_uses_rd = 1'b1; end
            OP_BEQ: w_branch = 1'b1;
            default: begin w_legal = 1'b0; w_uses_rs2 = 1'b0; end
        endcase
    end

    // Only a live LW in EX whose rd feeds a source this instruction actually reads.
    assign w_hazard = if_valid && !ex_flush && w_legal &&
                      r_ex_valid && r_ex_mem_read && (r_ex_rd != 3'd0) &&
                      ((r_ex_rd == w_rs1) ||
                       (w_uses_rs2 && r_ex_rd == w_rs2) ||
                       (w_uses_rd  && r_ex_rd == w_rd));

    assign id_stall = w_hazard && !reset;
    assign w_bubble = ex_flush || w_hazard || !if_valid || !w_legal;

    always_ff @(posedge clock) begin
        if (reset || w_bubble) begin
            r_ex_valid       <= 1'b0;
            r_ex_instruction <= NOP_INSTR;
            r_ex_control     <= ALU_ADD;
            r_ex_opA         <= '0;
            r_ex_opB         <= '0;
            r_ex_store       <= '0;
            r_ex_rd          <= 3'd0;
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_branch      <= 1'b0;
        end else begin
            r_ex_valid       <= 1'b1;
            r_ex_instruction <= if_instruction;
            r_ex_control     <= w_control;
            r_ex_opA         <= w_rdata1;
            r_ex_opB         <= w_rdata2;
            r_ex_store       <= w_rdata3;
            r_ex_rd          <= w_rd;
            r_ex_reg_write   <= w_reg_write;
            r_ex_mem_read    <= w_mem_read;
            r_ex_mem_write   <= w_mem_write;
            r_ex_branch      <= w_branch;
        end
    end

    assign ex_valid       = r_ex_valid;
    assign ex_instruction = r_ex_instruction;
    assign ex_control     = r_ex_control;
    assign ex_opA         = r_ex_opA;
    assign ex_rfReadData2 = r_ex_opB;
    assign ex_store_data  = r_ex_store;
    assign ex_rd          = r_ex_rd;
    assign ex_reg_write   = r_ex_reg_write;
    assign ex_mem_read    = r_ex_mem_read;
    assign ex_mem_write   = r_ex_mem_write;
    assign ex_branch      = r_ex_branch;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: expected ID/EX contents are queued as
// each instruction is driven and compared after the following clock edge.
module tb_instruction_decode;

    typedef struct packed {
        logic        valid;
        logic [19:0] instr;
        logic [1:0]  ctrl;
        logic [19:0] op_a;
        logic [19:0] op_b;
        logic [19:0] store;
        logic [2:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] if_instruction = 20'hF0000;
    logic        if_valid = 1'b0;
    logic        ex_flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [2:0]  wb_addr = 3'd0;
    logic [19:0] wb_data = 20'd0;
    logic        id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [19:0] ex_instruction, ex_opA, ex_rfReadData2, ex_store_data;
    logic [1:0]  ex_control;
    logic [2:0]  ex_rd;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb_q[$];

    always #5 clock = ~clock;

    instruction_decode dut (
        .clock          (clock),
        .reset          (reset),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .ex_flush       (ex_flush),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .id_stall       (id_stall),
        .ex_valid       (ex_valid),
        .ex_instruction (ex_instruction),
        .ex_control     (ex_control),
        .ex_opA         (ex_opA),
        .ex_rfReadData2 (ex_rfReadData2),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_branch      (ex_branch)
    );

    function automatic logic [19:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [6:0] off);
        return {op, rd, rs1, rs2, off};
    endfunction

    function automatic exp_t mk(input logic [19:0] instr, input logic [1:0] ctrl,
                                input logic [19:0] a, input logic [19:0] b, input logic [19:0] s,
                                input logic rw, input logic mr, input logic mw, input logic br);
        exp_t e;
        e.valid = 1'b1;
        e.instr = instr;
        e.ctrl  = ctrl;
        e.op_a  = a;
        e.op_b  = b;
        e.store = s;
        e.rd    = instr[15:13];
        e.rw    = rw;
        e.mr    = mr;
        e.mw    = mw;
        e.br    = br;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e = '0;
        e.instr = 20'hF0000;
        return e;
    endfunction

    task automatic step(input string tag, input logic rst, input logic [19:0] ins,
                        input logic iv, input logic fl, input logic we,
                        input logic [2:0] wa, input logic [19:0] wd,
                        input exp_t e, input logic stall_e);
        exp_t exp_v, got;
        reset          = rst;
        if_instruction = ins;
        if_valid       = iv;
        ex_flush       = fl;
        wb_we          = we;
        wb_addr        = wa;
        wb_data        = wd;
        #1;
        n_total++;
        assert (id_stall === stall_e) n_pass++;
        else $error("FAIL %s id_stall observed=%b expected=%b", tag, id_stall, stall_e);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = {ex_valid, ex_instruction, ex_control, ex_opA, ex_rfReadData2, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch};
        exp_v = sb_q.pop_front();
        n_total++;
        assert (got === exp_v) n_pass++;
        else $error("FAIL %s idex observed=%h expected=%h", tag, got, exp_v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "timeout");
    end

    initial begin
        logic [19:0] i_add, i_lw6, i_use6, i_sw;
        i_add  = enc(4'h0, 3'd3, 3'd1, 3'd2, 7'h15);
        i_lw6  = enc(4'h4, 3'd6, 3'd1, 3'd2, 7'h00);
        i_use6 = enc(4'h0, 3'd7, 3'd6, 3'd1, 7'h00);
        i_sw   = enc(4'h5, 3'd2, 3'd1, 3'd3, 7'h02);
        @(posedge clock); #1;

        step("reset0", 1, i_add, 1, 0, 0, 3'd0, 20'd0, bubble(), 0);
        step("reset1", 1, i_add, 1, 0, 0, 3'd0, 20'd0, bubble(), 0);
        step("wr_r1",  0, 20'hF0000, 0, 0, 1, 3'd1, 20'd5, bubble(), 0);
        step("wr_r2",  0, 20'hF0000, 0, 0, 1, 3'd2, 20'd3, bubble(), 0);
        step("add",    0, i_add, 1, 0, 0, 3'd0, 20'd0,
             mk(i_add, 2'b00, 20'd5, 20'd3, 20'd0, 1, 0, 0, 0), 0);
        step("not_byp", 0, enc(4'h3, 3'd5, 3'd4, 3'd0, 7'h00), 1, 0, 1, 3'd4, 20'h00ABC,
             mk(enc(4'h3, 3'd5, 3'd4, 3'd0, 7'h00), 2'b11, 20'h00ABC, 20'd0, 20'd0, 1, 0, 0, 0), 0);
        step("lw6",    0, i_lw6, 1, 0, 0, 3'd0, 20'd0,
             mk(i_lw6, 2'b00, 20'd5, 20'd3, 20'd0, 1, 1, 0, 0), 0);
        step("lu_stall", 0, i_use6, 1, 0, 0, 3'd0, 20'd0, bubble(), 1);
        step("lu_redo", 0, i_use6, 1, 0, 1, 3'd6, 20'h00077,
             mk(i_use6, 2'b00, 20'h00077, 20'd5, 20'd0, 1, 0, 0, 0), 0);
        step("lw_r0",  0, enc(4'h4, 3'd0, 3'd1, 3'd2, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h4, 3'd0, 3'd1, 3'd2, 7'h00), 2'b00, 20'd5, 20'd3, 20'd0, 1, 1, 0, 0), 0);
        step("not_r0", 0, enc(4'h3, 3'd7, 3'd0, 3'd0, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h3, 3'd7, 3'd0, 3'd0, 7'h00), 2'b11, 20'd0, 20'd0, 20'd0, 1, 0, 0, 0), 0);
        step("lw6_b",  0, i_lw6, 1, 0, 0, 3'd0, 20'd0,
             mk(i_lw6, 2'b00, 20'd5, 20'd3, 20'h00077, 1, 1, 0, 0), 0);
        step("flush",  0, enc(4'h1, 3'd3, 3'd6, 3'd1, 7'h00), 1, 1, 0, 3'd0, 20'd0, bubble(), 0);
        step("lw2",    0, enc(4'h4, 3'd2, 3'd1, 3'd0, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h4, 3'd2, 3'd1, 3'd0, 7'h00), 2'b00, 20'd5, 20'd0, 20'd3, 1, 1, 0, 0), 0);
        step("sw_stall", 0, i_sw, 1, 0, 0, 3'd0, 20'd0, bubble(), 1);
        step("sw",     0, i_sw, 1, 0, 0, 3'd0, 20'd0,
             mk(i_sw, 2'b00, 20'd5, 20'd0, 20'd3, 0, 0, 1, 0), 0);
        step("beq",    0, enc(4'h6, 3'd0, 3'd1, 3'd1, 7'h7F), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h6, 3'd0, 3'd1, 3'd1, 7'h7F), 2'b00, 20'd5, 20'd5, 20'd0, 0, 0, 0, 1), 0);
        step("wr_r0",  0, 20'hF0000, 0, 0, 1, 3'd0, 20'hFFFFF, bubble(), 0);
        step("add_r0", 0, enc(4'h0, 3'd1, 3'd0, 3'd0, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h0, 3'd1, 3'd0, 3'd0, 7'h00), 2'b00, 20'd0, 20'd0, 20'd5, 1, 0, 0, 0), 0);
        step("lw4",    0, enc(4'h4, 3'd4, 3'd1, 3'd2, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h4, 3'd4, 3'd1, 3'd2, 7'h00), 2'b00, 20'd5, 20'd3, 20'h00ABC, 1, 1, 0, 0), 0);
        step("not_rs2", 0, enc(4'h3, 3'd5, 3'd1, 3'd4, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h3, 3'd5, 3'd1, 3'd4, 7'h00), 2'b11, 20'd5, 20'h00ABC, 20'd0, 1, 0, 0, 0), 0);
        step("lw4_b",  0, enc(4'h4, 3'd4, 3'd1, 3'd2, 7'h00), 1, 0, 0, 3'd0, 20'd0,
             mk(enc(4'h4, 3'd4, 3'd1, 3'd2, 7'h00), 2'b00, 20'd5, 20'd3, 20'h00ABC, 1, 1, 0, 0), 0);
        step("invalid", 0, enc(4'h0, 3'd7, 3'd4, 3'd1, 7'h00), 0, 0, 0, 3'd0, 20'd0, bubble(), 0);
        step("illegal", 0, enc(4'h7, 3'd1, 3'd1, 3'd2, 7'h00), 1, 0, 0, 3'd0, 20'd0, bubble(), 0);
        step("lw6_c",  0, i_lw6, 1, 0, 0, 3'd0, 20'd0,
             mk(i_lw6, 2'b00, 20'd5, 20'd3, 20'h00077, 1, 1, 0, 0), 0);
        step("rst_mid", 1, i_use6, 1, 0, 0, 3'd0, 20'd0, bubble(), 0);
        step("post_rst", 0, i_add, 1, 0, 0, 3'd0, 20'd0,
             mk(i_add, 2'b00, 20'd0, 20'd0, 20'd0, 1, 0, 0, 0), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
